// File: rtl/phase_ctrl.sv
// Multi-cycle F/R/X/W control sequencer for the cpu_ex datapath with retired-instruction counter.
// Optional single-step gating of fetch is enabled by defining PHASE_CTRL_STEP_EN.
module phase_ctrl #(
    parameter logic [5:0]  OPC_ADD = 6'h00,
    parameter logic [5:0]  OPC_NOP = 6'h01,
    parameter logic [5:0]  OPC_HLT = 6'h3F,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [31:0]      ir,
    input  logic             mem_rdy,
`ifdef PHASE_CTRL_STEP_EN
    input  logic             step,
`endif
    output logic             fetch_req,
    output logic [3:0]       phase,
    output logic             we_ir,
    output logic             we_tr,
    output logic             we_sr,
    output logic             we_dr,
    output logic             we_rf,
    output logic             hlt,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_READ,
        S_EXEC,
        S_WRITE,
        S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             err_q, err_d;
    logic             tok;
    logic [5:0]       opcode;
    logic             unused_ir;

    assign opcode    = ir[31:26];
    assign unused_ir = ^ir[25:0];

`ifdef PHASE_CTRL_STEP_EN
    logic token_q, token_d;
    assign tok = token_q;
`else
    assign tok = 1'b1;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
            err_q     <= 1'b0;
`ifdef PHASE_CTRL_STEP_EN
            token_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            err_q     <= err_d;
`ifdef PHASE_CTRL_STEP_EN
            token_q   <= token_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        retired_d = retired_q;
        err_d     = err_q;
        fetch_req = 1'b0;
        phase     = 4'b0000;
        we_ir     = 1'b0;
        we_tr     = 1'b0;
        we_sr     = 1'b0;
        we_dr     = 1'b0;
        we_rf     = 1'b0;
        hlt       = 1'b0;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                phase     = 4'b0001;
                fetch_req = tok;
                if (tok && mem_rdy) begin
                    we_ir   = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                phase = 4'b0010;
                if (opcode == OPC_ADD) begin
                    we_tr   = 1'b1;
                    we_sr   = 1'b1;
                    state_d = S_EXEC;
                end else if (opcode == OPC_NOP) begin
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = S_FETCH;
                end else if (opcode == OPC_HLT) begin
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = S_HALT;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_EXEC: begin
                phase   = 4'b0100;
                we_dr   = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                phase     = 4'b1000;
                we_rf     = 1'b1;
                retired_d = retired_q + CNT_W'(1);
                state_d   = S_FETCH;
            end
            S_HALT: hlt = 1'b1;
            default: state_d = S_IDLE;
        endcase
`ifdef PHASE_CTRL_STEP_EN
        // Consuming the token on the fetch handshake takes priority over a coincident step.
        token_d = token_q;
        if (step && state_q != S_HALT) token_d = 1'b1;
        if (we_ir) token_d = 1'b0;
`endif
    end

    assign err     = err_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_phase_ctrl.sv
// Bench for phase_ctrl: instruction-level reference model checked every cycle plus directed literals.
// Two instances share stimulus: default counter width and CNT_W=4 for the wrap case.
module tb_phase_ctrl;

    localparam logic [31:0] I_ADD = 32'h0009_0000;
    localparam logic [31:0] I_NOP = 32'h0400_0000;
    localparam logic [31:0] I_HLT = 32'hFC00_0000;
    localparam logic [31:0] I_ILL = 32'h0800_0000;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        mem_rdy = 1'b0;
    logic [31:0] ir = 32'h0;
`ifdef PHASE_CTRL_STEP_EN
    logic        step = 1'b0;
`endif

    logic        fr_a, wir_a, wtr_a, wsr_a, wdr_a, wrf_a, hlt_a, err_a;
    logic [3:0]  ph_a;
    logic [15:0] ret_a;
    logic        fr_b, wir_b, wtr_b, wsr_b, wdr_b, wrf_b, hlt_b, err_b;
    logic [3:0]  ph_b;
    logic [3:0]  ret_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    phase_ctrl dut_a (
        .clk(clk), .n_rst(n_rst), .ir(ir), .mem_rdy(mem_rdy),
`ifdef PHASE_CTRL_STEP_EN
        .step(step),
`endif
        .fetch_req(fr_a), .phase(ph_a), .we_ir(wir_a), .we_tr(wtr_a), .we_sr(wsr_a),
        .we_dr(wdr_a), .we_rf(wrf_a), .hlt(hlt_a), .err(err_a), .retired(ret_a)
    );

    phase_ctrl #(.CNT_W(4)) dut_b (
        .clk(clk), .n_rst(n_rst), .ir(ir), .mem_rdy(mem_rdy),
`ifdef PHASE_CTRL_STEP_EN
        .step(step),
`endif
        .fetch_req(fr_b), .phase(ph_b), .we_ir(wir_b), .we_tr(wtr_b), .we_sr(wsr_b),
        .we_dr(wdr_b), .we_rf(wrf_b), .hlt(hlt_b), .err(err_b), .retired(ret_b)
    );

    // Model: position inside the current instruction (0 = fetch slot) and its length by opcode.
    logic        m_started = 1'b0;
    logic        m_halted = 1'b0;
    logic        m_err = 1'b0;
    int          m_pos = 0;
    int unsigned m_ret = 0;
    logic        tok_eff;
    logic [5:0]  op;
    logic        fetch_now;

    assign op = ir[31:26];

    function automatic logic is_legal(input logic [5:0] o);
        return (o == 6'h00) || (o == 6'h01) || (o == 6'h3F);
    endfunction

    function automatic int ilen(input logic [5:0] o);
        return (o == 6'h00) ? 4 : 2;
    endfunction

`ifdef PHASE_CTRL_STEP_EN
    logic m_tok = 1'b0;
    assign tok_eff = m_tok;
`else
    assign tok_eff = 1'b1;
`endif

    assign fetch_now = m_started && !m_halted && (m_pos == 0) && tok_eff && mem_rdy;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_started <= 1'b0;
            m_halted  <= 1'b0;
            m_err     <= 1'b0;
            m_pos     <= 0;
            m_ret     <= 0;
`ifdef PHASE_CTRL_STEP_EN
            m_tok     <= 1'b0;
`endif
        end else begin
            if (!m_started) begin
                m_started <= 1'b1;
            end else if (!m_halted) begin
                if (m_pos == 0) begin
                    if (fetch_now) m_pos <= 1;
                end else if (m_pos == ilen(op) - 1) begin
                    if (is_legal(op)) m_ret <= m_ret + 1;
                    if (!is_legal(op)) m_err <= 1'b1;
                    if (op == 6'h3F || !is_legal(op)) m_halted <= 1'b1;
                    else m_pos <= 0;
                end else begin
                    m_pos <= m_pos + 1;
                end
            end
`ifdef PHASE_CTRL_STEP_EN
            m_tok <= fetch_now ? 1'b0 : (m_tok | (step & ~m_halted));
`endif
        end
    end

    logic [11:0] exp_ctl;
    always_comb begin
        logic act_run;
        logic [3:0] e_ph;
        logic e_fr;
        act_run = m_started && !m_halted;
        e_ph    = act_run ? (4'b0001 << m_pos) : 4'b0000;
        e_fr    = act_run && (m_pos == 0) && tok_eff;
        exp_ctl = {e_ph, e_fr, e_fr && mem_rdy,
                   act_run && (m_pos == 1) && (op == 6'h00),
                   act_run && (m_pos == 1) && (op == 6'h00),
                   act_run && (m_pos == 2), act_run && (m_pos == 3),
                   m_halted, m_err};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("cyc_ctl_a", 32'({ph_a, fr_a, wir_a, wtr_a, wsr_a, wdr_a, wrf_a, hlt_a, err_a}), 32'(exp_ctl));
        check("cyc_ret_a", 32'(ret_a), 32'(m_ret[15:0]));
        check("cyc_ctl_b", 32'({ph_b, fr_b, wir_b, wtr_b, wsr_b, wdr_b, wrf_b, hlt_b, err_b}), 32'(exp_ctl));
        check("cyc_ret_b", 32'(ret_b), 32'(m_ret[3:0]));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_zero(input string name);
        check(name, 32'({ph_a, fr_a, wir_a, wtr_a, wsr_a, wdr_a, wrf_a, hlt_a, err_a}), 32'h0);
        check({name, "_ret"}, 32'(ret_a), 32'h0);
    endtask

    task automatic reset_pulse();
        n_rst = 1'b0;
        #1 check_zero("rst_assert");
        tick();
        n_rst = 1'b1;
        #1 check("rst_idle_phase", 32'(ph_a), 32'h0);
        tick();
    endtask

    initial begin
        mem_rdy = 1'b1;
        ir      = I_ADD;
        repeat (2) tick();
        #1 check_zero("t1_reset");
        n_rst = 1'b1;
        tick();
        // Test 1: one ADD end to end
        #1 check("t1_f_phase", 32'(ph_a), 32'h1);
        check("t1_we_ir", 32'(wir_a), 32'h1);
        tick();
        #1 check("t1_r_phase", 32'(ph_a), 32'h2);
        check("t1_we_trsr", 32'({wtr_a, wsr_a}), 32'h3);
        tick();
        #1 check("t1_x_phase", 32'(ph_a), 32'h4);
        check("t1_we_dr", 32'(wdr_a), 32'h1);
        tick();
        #1 check("t1_w_phase", 32'(ph_a), 32'h8);
        check("t1_we_rf", 32'(wrf_a), 32'h1);
        tick();
        #1 check("t1_back_f", 32'(ph_a), 32'h1);
        check("t1_retired", 32'(ret_a), 32'h1);

        // Test 2: fetch stall
        mem_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 check("t2_stall", 32'({ph_a, fr_a, wir_a}), 32'b0001_1_0);
            tick();
        end
        mem_rdy = 1'b1;
        #1 check("t2_we_ir", 32'(wir_a), 32'h1);
        tick();
        #1 check("t2_read", 32'(ph_a), 32'h2);
        repeat (3) tick();
        #1 check("t2_retired", 32'(ret_a), 32'h2);

        // Test 3: NOP then HLT
        reset_pulse();
        ir = I_NOP;
        tick();
        #1 check("t3_nop_r", 32'({ph_a, wtr_a}), 32'b0010_0);
        tick();
        #1 check("t3_nop_f", 32'({ph_a, ret_a}), {12'h0, 4'h1, 16'h1});
        ir = I_HLT;
        repeat (2) tick();
        #1 check("t3_halt", 32'({hlt_a, ph_a}), 32'b1_0000);
        check("t3_ret", 32'(ret_a), 32'h2);
        repeat (20) tick();
        #1 check("t3_still_halt", 32'({hlt_a, ph_a, fr_a}), 32'b1_0000_0);
        check("t3_ret_hold", 32'(ret_a), 32'h2);

        // Test 4: illegal opcode
        reset_pulse();
        ir = I_ILL;
        repeat (2) tick();
        #1 check("t4_err_hlt", 32'({err_a, hlt_a}), 32'b11);
        check("t4_ret", 32'(ret_a), 32'h0);
        reset_pulse();

        // Test 5: counter wrap at CNT_W=4, then reset during EXEC
        ir = I_NOP;
        for (int i = 1; i <= 16; i++) begin
            repeat (2) tick();
            if (i == 15) begin
                #1 check("t5_b_F", 32'(ret_b), 32'hF);
            end
        end
        #1 check("t5_b_wrap", 32'(ret_b), 32'h0);
        check("t5_a_16", 32'(ret_a), 32'h10);
        ir = I_ADD;
        repeat (2) tick();
        #1 check("t5_exec_dr", 32'({ph_a, wdr_a}), 32'b0100_1);
        n_rst = 1'b0;
        #1 check("t5_rst_dr", 32'({ph_a, wdr_a, ret_a}), 32'h0);
        tick();
        n_rst = 1'b1;
        tick();

`ifdef PHASE_CTRL_STEP_EN
        // Test 6: single-step gating
        mem_rdy = 1'b1;
        ir      = I_ADD;
        for (int i = 0; i < 10; i++) begin
            #1 check("t6_no_step", 32'({ph_a, fr_a}), 32'b0001_0);
            tick();
        end
        for (int p = 1; p <= 3; p++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            #1 check("t6_fetch", 32'({fr_a, wir_a}), 32'b11);
            repeat (6) tick();
            #1 check("t6_idle_f", 32'({ph_a, fr_a}), 32'b0001_0);
            check("t6_ret", 32'(ret_a), 32'(p));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
